breadboard_sweeper: RTL
=======================

# breadboard_sweeper

Sequencer that exhaustively exercises the 4-input / 10-output combinational breadboard truth-table block. It steps the breadboard inputs through all 16 combinations and waits a programmable settle time on each. It then captures the 10 outputs and hands each result to a downstream consumer over a valid/ready handshake. It keeps a running 10-bit signature of the whole sweep for pass/fail comparison against a golden value.

## Interface

- SETTLE, default 4: cycles the inputs are held before outputs are sampled; legal range 1..255 (0 illegal).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a sweep; sampled only in IDLE.
- busy  out  1  high in SETTLE, PRESENT and DONE.
- done  out  1  one-cycle pulse when the sweep completes.
- w, x, y, z  out  1 each  breadboard inputs; w=idx[3], x=idx[2], y=idx[1], z=idx[0].
- r  in  10  breadboard outputs; r[k] = rk.
- out_valid  out  1  captured result available.
- out_ready  in  1  consumer accepts the result.
- out_idx  out  4  input combination of the presented result.
- out_data  out  10  captured r for out_idx.
- sig  out  10  running signature.

## Operation

- Registers: idx (4 b), settle counter (8 b), out_data (10 b), sig (10 b), state.
- w/x/y/z are driven combinationally from idx at all times.
- IDLE: busy=0.
  - start=1 → idx←0, sig←0, counter←SETTLE-1, go to SETTLE.
- SETTLE:
  - counter≠0 → decrement.
  - counter=0 → out_data←r, out_idx←idx, go to PRESENT.
- PRESENT: out_valid=1.
  - out_data and out_idx are held stable until acceptance; changes on r are ignored.
  - On out_valid & out_ready: sig←{sig[8:0],sig[9]} ^ out_data.
  - If idx=15 → go to DONE. Otherwise idx←idx+1, counter←SETTLE-1, go to SETTLE.
- DONE: done=1 for exactly one cycle, then → IDLE.
  - idx stays 15.
  - sig holds its final value until the next accepted start.
- start outside IDLE is ignored, including in the DONE cycle; it has no queueing effect.
- out_valid may only fall in the cycle after a transfer.

## Timing

- Reset (asynchronous, any state):
  - State → IDLE.
  - idx=0, so w=x=y=z=0.
  - out_valid=0, out_idx=0, out_data=0, sig=0, busy=0, done=0.
  - Reset asserted mid-sweep aborts the sweep; the pending result is dropped.
- Start: start high at edge E → SETTLE from E+1.
- Settle: inputs for each vector are stable for exactly SETTLE cycles before the capture edge.
- Per-vector latency: out_valid rises SETTLE+1 cycles after start is accepted, or after the previous transfer edge.
- Full sweep with out_ready tied high:
  - 16 × (SETTLE+1) cycles from the start edge to the last transfer.
  - done is high in the following cycle.
  - busy falls one cycle after that.
- Backpressure: with out_ready low, the block stalls in PRESENT indefinitely. idx, w/x/y/z and out_data are all frozen.
- Wrap: idx never wraps within a sweep. The transition 15→DONE replaces the increment.

## Test plan

- Reset values: assert rst mid-cycle with clk stopped → all outputs 0 immediately. Release rst, pulse start → busy=1 on the next edge.
- Full sweep, SETTLE=4, out_ready=1, real breadboard attached:
  - First out_valid appears 5 cycles after start.
  - Transfers follow: idx0 out_data=0x020, idx1 0x260, idx3 0x1F3.
  - sig=0x020 after the first transfer and 0x220 after the second.
  - The final sig matches the reference model.
  - done pulses once, 80 cycles + 1 after the start edge.
- Backpressure: hold out_ready=0 for 20 cycles at idx=3 → out_valid=1, out_data=0x1F3, idx and wxyz=0011 stable throughout; sig unchanged until out_ready=1.
- Start while busy: pulse start during SETTLE, PRESENT and DONE → no restart, sig not cleared, exactly 16 transfers and a single done.
- Reset mid-operation: assert rst in PRESENT at idx=7 → out_valid=0, idx=0, sig=0. A new start produces a clean sweep beginning at idx0 = 0x020.
- SETTLE=1 corner: out_ready=1 → a transfer every 2 cycles, 32 cycles per sweep; captured data identical to the SETTLE=4 run.

Source files
------------

// File: rtl/breadboard_sweeper.sv
// Steps a 4-input breadboard through all 16 vectors, captures each
// 10-bit result, hands it downstream and folds it into a signature.
module breadboard_sweeper #(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  input  logic [9:0] r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_idx,
  output logic [9:0] out_data,
  output logic [9:0] sig
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [7:0] LOAD = 8'(SETTLE - 1);

  state_t     state;
  state_t     state_d;
  logic [3:0] idx;
  logic [7:0] cnt;
  logic       clr;
  logic       dec;
  logic       cap;
  logic       xfer;
  logic       adv;

  assign w = idx[3];
  assign x = idx[2];
  assign y = idx[1];
  assign z = idx[0];

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign out_valid = (state == S_PRESENT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    clr     = 1'b0;
    dec     = 1'b0;
    cap     = 1'b0;
    xfer    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt != 8'd0) begin
          dec = 1'b1;
        end else begin
          cap     = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          xfer = 1'b1;
          // last vector ends the sweep instead of wrapping idx
          if (idx == 4'hF) begin
            state_d = S_DONE;
          end else begin
            adv     = 1'b1;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= 4'd0;
      cnt      <= 8'd0;
      out_idx  <= 4'd0;
      out_data <= 10'd0;
      sig      <= 10'd0;
    end else begin
      if (clr) begin
        idx <= 4'd0;
        sig <= 10'd0;
        cnt <= LOAD;
      end
      if (dec) begin
        cnt <= cnt - 8'd1;
      end
      if (cap) begin
        out_data <= r;
        out_idx  <= idx;
      end
      if (xfer) begin
        sig <= {sig[8:0], sig[9]} ^ out_data;
      end
      if (adv) begin
        idx <= idx + 4'd1;
        cnt <= LOAD;
      end
    end
  end

endmodule
